control_unit: RTL and testbench
===============================

# control_unit

Instruction sequencer between the program ROM and the operand stack. It consumes each 16-bit instruction word the ROM returns for the current `pc`, decodes it, and drives the program-counter controls and the stack push/pop ports. It also tracks stack occupancy so that underflow and overflow are caught before they reach the stack, and halts on `HALT` or on any fault.

## Interface
- `PC_W`, 11: program counter width.
- `INSTR_W`, 16: instruction word width.
- `DATA_W`, 256: stack word width.
- `STACK_DEPTH`, 128: stack capacity in entries.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `instr` in INSTR_W: ROM data for the `pc` presented in the previous cycle.
- `top0` in DATA_W: stack preview entry 0 (top of stack).
- `top1` in DATA_W: stack preview entry 1 (second from top).
- `pc_inc` out 1: increment the program counter this cycle.
- `pc_load` out 1: load `pc_load_val` into the program counter this cycle.
- `pc_load_val` out PC_W: jump target.
- `stack_push` out 1: push `stack_push_data`.
- `stack_push_data` out DATA_W: word to push.
- `stack_pop` out 3: number of entries to pop this cycle (0–7).
- `depth` out $clog2(STACK_DEPTH)+1: current stack occupancy.
- `halted` out 1: sequencer is stopped.
- `fault` out 2: 0 none, 1 underflow, 2 overflow, 3 illegal opcode. Sticky until reset.

## Operation
- Instruction format: `instr[15:12]` is the opcode; `instr[11:0]` is `imm`.
- NOP (0x0): no stack action.
- PUSHI (0x1): push `imm` zero-extended to DATA_W. Requires `depth < STACK_DEPTH`.
- POP (0x2): pop `imm[2:0]` entries. Requires `depth >= imm[2:0]`. A count of 0 behaves as NOP.
- ADD (0x3): pop 2, then push `top0 + top1` modulo 2^DATA_W with no carry out. Requires `depth >= 2`.
- JMP (0x4): `pc_load_val = imm[PC_W-1:0]`. When PC_W > 12 the target is zero-extended.
- JZ (0x5): pop 1. If `top0 == 0`, jump to `imm`; otherwise increment. Requires `depth >= 1`.
- HALT (0xF): enter HALT. The pc is not incremented.
- Any other opcode: set `fault = 3` and enter HALT.
- Every non-jump instruction that completes asserts `pc_inc` exactly once.
- Checks run in EXEC, before any strobe is issued. A failed check asserts no strobes, sets `fault`, and enters HALT.
- `depth` changes in the same cycle as the corresponding push/pop strobe: +1 per push, −n per pop.

## Timing
- FSM states: RESET, FETCH, EXEC, WB, HALT.
- RESET → FETCH on the first edge after `rst` deasserts.
- FETCH: all strobes 0. The pc is stable while the ROM read is in flight. Next state is EXEC.
- EXEC: `instr` is valid in this cycle. Decode, check, then issue strobes. ADD goes to WB; every other opcode goes to FETCH or HALT.
- ADD in EXEC: `stack_pop = 2`; latch `top0 + top1` into the sum register. No pc strobe.
- WB: `stack_push = 1` with the latched sum; `pc_inc = 1`. Next state is FETCH.
- HALT: absorbing state; all strobes 0; `halted = 1`. Only reset leaves it.
- Cycles per instruction: 2 for all opcodes except ADD, which takes 3.
- `pc_inc` and `pc_load` are never asserted together. `stack_push` and a nonzero `stack_pop` are never asserted in the same cycle.
- Reset values: all strobes 0, `pc_load_val = 0`, `stack_push_data = 0`, `depth = 0`, `halted = 0`, `fault = 0`, sum register 0, state RESET.
- Reset asserted mid-instruction, including in WB, clears everything asynchronously. A half-completed ADD is abandoned, and `depth` returns to 0 together with the stack.

## Structure
- Package `em_pkg` holds the opcode enum, the FSM state enum, the fault codes, and the `INSTR_W` and `DATA_W` constants. The Processor top level imports the same package.
- No sub-module: a single FSM with an inline DATA_W-bit adder. The sum register is what keeps the adder off the stack write path.

## Test plan
- Sequence PUSHI 5, PUSHI 7, ADD, HALT → pushes 5, 7, then 12 in the WB cycle. `depth` goes 1, 2, 0, 1; `halted = 1` with `fault = 0`; `pc_inc` pulses 3 times in total.
- ADD with `top0 = top1 = 2^256−1` → pushes 2^256−2 (wraps, no fault).
- JZ 0x040 with `top0 = 0` → `pc_load = 1`, `pc_load_val = 0x040`, `stack_pop = 1`. Repeat with `top0 = 3` → `pc_inc = 1`, no load.
- POP 3 at `depth = 2` → no strobes issued, `fault = 1`, `halted = 1`. Fill the stack to 128 entries, then PUSHI → `fault = 2`, no push issued.
- Opcode 0x9 → `fault = 3`, HALT. A later edge with `rst = 1` changes nothing.
- Assert `rst = 0` during the WB cycle of an ADD → all outputs 0 immediately, with no clock edge needed. After release, execution restarts at the FETCH of pc 0.

Source files
------------

// File: rtl/em_pkg.sv
// Shared definitions for the instruction sequencer.
//   - INSTR_W / DATA_W : instruction word and stack word widths
//   - opcode_e         : values of instr[15:12]
//   - state_e          : sequencer FSM states
//   - fault_e          : sticky fault codes reported on the fault output
package em_pkg;

  localparam int INSTR_W = 16;
  localparam int DATA_W  = 256;
  localparam int OPC_W   = 4;
  localparam int IMM_W   = 12;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_PUSHI = 4'h1,
    OP_POP   = 4'h2,
    OP_ADD   = 4'h3,
    OP_JMP   = 4'h4,
    OP_JZ    = 4'h5,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE      = 2'd0,
    FAULT_UNDERFLOW = 2'd1,
    FAULT_OVERFLOW  = 2'd2,
    FAULT_ILLEGAL   = 2'd3
  } fault_e;

endpackage

// File: rtl/control_unit.sv
// Instruction sequencer between the program ROM and the operand stack.
// Each instruction is fetched (FETCH), decoded and checked (EXEC) and, for
// ADD only, completed by a write-back cycle (WB). Stack occupancy is tracked
// here so illegal pops/pushes are stopped before any strobe reaches the stack.
//
// Ports:
//   clk             : clock, rising edge
//   rst             : asynchronous reset, active low
//   instr           : ROM word for the pc presented in the previous cycle
//   top0 / top1     : stack preview, top and second-from-top entries
//   pc_inc, pc_load : program counter controls (never both high)
//   pc_load_val     : jump target, valid with pc_load
//   stack_push      : push stack_push_data this cycle
//   stack_push_data : word to push (zero when not pushing)
//   stack_pop       : number of entries popped this cycle
//   depth           : current stack occupancy
//   halted          : sequencer stopped (HALT instruction or fault)
//   fault           : sticky fault code (see em_pkg::fault_e)
//   state_dbg       : current FSM state, for observation only
//
// Handshake: there is no back-pressure. Every strobe is a single-cycle
// command that the pc register and the stack must act on at the next rising
// edge; depth is updated on that same edge.
module control_unit
  import em_pkg::*;
#(
  parameter  int PC_W        = 11,
  parameter  int STACK_DEPTH = 128,
  localparam int DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  top0,
  input  logic [DATA_W-1:0]  top1,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_val,
  output logic               stack_push,
  output logic [DATA_W-1:0]  stack_push_data,
  output logic [2:0]         stack_pop,
  output logic [DEPTH_W-1:0] depth,
  output logic               halted,
  output logic [1:0]         fault,
  output state_e             state_dbg
);

  state_e               state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [1:0]           fault_q, fault_d;
  logic [DATA_W-1:0]    sum_q, sum_d;

  logic [OPC_W-1:0]     opcode;
  logic [IMM_W-1:0]     imm;
  logic [2:0]           pop_n;
  logic [PC_W-1:0]      jump_target;

  assign opcode      = instr[INSTR_W-1 -: OPC_W];
  assign imm         = instr[IMM_W-1:0];
  assign pop_n       = imm[2:0];
  // Truncates when PC_W < 12, zero-extends when PC_W > 12.
  assign jump_target = PC_W'(imm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RESET;
      depth_q <= '0;
      fault_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    depth_d         = depth_q;
    fault_d         = fault_q;
    sum_d           = sum_q;
    pc_inc          = 1'b0;
    pc_load         = 1'b0;
    pc_load_val     = '0;
    stack_push      = 1'b0;
    stack_push_data = '0;
    stack_pop       = '0;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;

      ST_FETCH: state_d = ST_EXEC;

      ST_EXEC: begin
        state_d = ST_FETCH;
        // Each branch checks occupancy first; a failed check issues no
        // strobe at all and parks the FSM in HALT.
        case (opcode)
          OP_NOP: pc_inc = 1'b1;

          OP_PUSHI: begin
            if (depth_q < DEPTH_W'(STACK_DEPTH)) begin
              stack_push      = 1'b1;
              stack_push_data = DATA_W'(imm);
              pc_inc          = 1'b1;
              depth_d         = depth_q + DEPTH_W'(1);
            end else begin
              fault_d = FAULT_OVERFLOW;
              state_d = ST_HALT;
            end
          end

          OP_POP: begin
            if (depth_q >= DEPTH_W'(pop_n)) begin
              stack_pop = pop_n;
              pc_inc    = 1'b1;
              depth_d   = depth_q - DEPTH_W'(pop_n);
            end else begin
              fault_d = FAULT_UNDERFLOW;
              state_d = ST_HALT;
            end
          end

          OP_ADD: begin
            // The sum is registered so the wide adder never sits on the
            // stack write path; the push happens from sum_q in WB.
            if (depth_q >= DEPTH_W'(2)) begin
              stack_pop = 3'd2;
              sum_d     = top0 + top1;
              depth_d   = depth_q - DEPTH_W'(2);
              state_d   = ST_WB;
            end else begin
              fault_d = FAULT_UNDERFLOW;
              state_d = ST_HALT;
            end
          end

          OP_JMP: begin
            pc_load     = 1'b1;
            pc_load_val = jump_target;
          end

          OP_JZ: begin
            if (depth_q >= DEPTH_W'(1)) begin
              stack_pop = 3'd1;
              depth_d   = depth_q - DEPTH_W'(1);
              if (top0 == '0) begin
                pc_load     = 1'b1;
                pc_load_val = jump_target;
              end else begin
                pc_inc = 1'b1;
              end
            end else begin
              fault_d = FAULT_UNDERFLOW;
              state_d = ST_HALT;
            end
          end

          OP_HALT: state_d = ST_HALT;

          default: begin
            fault_d = FAULT_ILLEGAL;
            state_d = ST_HALT;
          end
        endcase
      end

      ST_WB: begin
        stack_push      = 1'b1;
        stack_push_data = sum_q;
        pc_inc          = 1'b1;
        depth_d         = depth_q + DEPTH_W'(1);
        state_d         = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_HALT;
    endcase
  end

  assign depth     = depth_q;
  assign fault     = fault_q;
  assign halted    = (state_q == ST_HALT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit. The bench plays the role of the program ROM,
// the pc register and the operand stack, and compares the sequencer's
// behaviour against an instruction-level interpreter of the program.
module tb_control_unit;
  import em_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [15:0]  instr;
  logic [255:0] top0, top1;
  logic         pc_inc, pc_load, stack_push, halted;
  logic [10:0]  pc_load_val;
  logic [255:0] stack_push_data;
  logic [2:0]   stack_pop;
  logic [7:0]   depth;
  logic [1:0]   fault;
  state_e       state_dbg;

  control_unit #(.PC_W(11), .STACK_DEPTH(128)) dut (
    .clk(clk), .rst(rst), .instr(instr), .top0(top0), .top1(top1),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .stack_push(stack_push), .stack_push_data(stack_push_data),
    .stack_pop(stack_pop), .depth(depth), .halted(halted), .fault(fault),
    .state_dbg(state_dbg)
  );

  // ---------------- environment: ROM, pc, stack ----------------
  logic [15:0]  rom [0:2047];
  logic [255:0] mem [0:255];
  logic [10:0]  pc;
  int           sp;
  logic         ovr;
  logic [255:0] ovr0, ovr1;

  always_comb begin
    top0 = '0;
    top1 = '0;
    if (ovr) begin
      top0 = ovr0;
      top1 = ovr1;
    end else begin
      if (sp >= 1 && sp <= 256) top0 = mem[8'(sp - 1)];
      if (sp >= 2 && sp <= 257) top1 = mem[8'(sp - 2)];
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      instr <= '0;
      sp    <= 0;
    end else begin
      instr <= rom[pc];
      if (pc_load) pc <= pc_load_val;
      else if (pc_inc) pc <= pc + 11'd1;
      if (stack_push) begin
        if (sp >= 0 && sp < 256) mem[8'(sp)] <= stack_push_data;
        sp <= sp + 1;
      end else if (stack_pop != 3'd0) begin
        sp <= sp - int'(stack_pop);
      end
    end
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  // observed
  logic [255:0] obs_q[$];
  logic [7:0]   obs_depth_q[$];
  int           obs_inc, obs_load, obs_pop_total, obs_proto, obs_cycles;
  logic [10:0]  obs_last_load;
  bit           timed_out;

  // expected (scoreboard)
  logic [255:0] exp_q[$];
  logic [7:0]   exp_depth_q[$];
  int           exp_inc, exp_load, exp_pop_total, exp_cycles;
  logic [10:0]  exp_last_load;
  logic [1:0]   exp_fault;

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 16'hF000;
  endtask

  // Instruction-level interpreter: walks the program, keeping the stack as
  // a queue of values, and predicts pushes, occupancy changes, pc activity,
  // fault code and the number of clock edges until halt.
  task automatic ref_run(input bit ovr_m, input logic [255:0] o0, input logic [255:0] o1);
    logic [255:0] st[$];
    logic [10:0]  mpc;
    logic [15:0]  w;
    logic [3:0]   op;
    logic [11:0]  imm;
    logic [255:0] t0, t1, s;
    int           d, n, steps;
    bit           done;
    exp_q.delete();
    exp_depth_q.delete();
    exp_inc = 0; exp_load = 0; exp_pop_total = 0; exp_cycles = 1;
    exp_last_load = '0; exp_fault = 2'd0;
    mpc = '0; done = 0; steps = 0;
    while (!done && steps < 2000) begin
      steps++;
      w   = rom[mpc];
      op  = w[15:12];
      imm = w[11:0];
      d   = st.size();
      t0  = ovr_m ? o0 : (d >= 1 ? st[d-1] : '0);
      t1  = ovr_m ? o1 : (d >= 2 ? st[d-2] : '0);
      exp_cycles += 2;
      case (op)
        4'h0: begin exp_inc++; mpc++; end
        4'h1: begin
          if (d >= 128) begin exp_fault = 2'd2; done = 1; end
          else begin
            st.push_back(256'(imm));
            exp_q.push_back(256'(imm));
            exp_depth_q.push_back(8'(d + 1));
            exp_inc++; mpc++;
          end
        end
        4'h2: begin
          n = int'(imm[2:0]);
          if (n > d) begin exp_fault = 2'd1; done = 1; end
          else begin
            for (int k = 0; k < n; k++) void'(st.pop_back());
            if (n > 0) exp_depth_q.push_back(8'(d - n));
            exp_pop_total += n;
            exp_inc++; mpc++;
          end
        end
        4'h3: begin
          if (d < 2) begin exp_fault = 2'd1; done = 1; end
          else begin
            void'(st.pop_back());
            void'(st.pop_back());
            s = t0 + t1;
            st.push_back(s);
            exp_q.push_back(s);
            exp_depth_q.push_back(8'(d - 2));
            exp_depth_q.push_back(8'(d - 1));
            exp_pop_total += 2;
            exp_inc++; mpc++;
            exp_cycles += 1;
          end
        end
        4'h4: begin mpc = imm[10:0]; exp_load++; exp_last_load = imm[10:0]; end
        4'h5: begin
          if (d < 1) begin exp_fault = 2'd1; done = 1; end
          else begin
            void'(st.pop_back());
            exp_depth_q.push_back(8'(d - 1));
            exp_pop_total += 1;
            if (t0 == '0) begin mpc = imm[10:0]; exp_load++; exp_last_load = imm[10:0]; end
            else begin exp_inc++; mpc++; end
          end
        end
        4'hF: done = 1;
        default: begin exp_fault = 2'd3; done = 1; end
      endcase
    end
  endtask

  // Reset, release, then watch the DUT once per cycle (at the falling edge)
  // until it halts, optionally stops at the first WB cycle, or the budget ends.
  task automatic run_prog(input int budget, input bit stop_wb);
    logic [7:0] prev_depth;
    bit         done;
    rst = 1'b0;
    obs_q.delete();
    obs_depth_q.delete();
    obs_inc = 0; obs_load = 0; obs_pop_total = 0; obs_proto = 0; obs_cycles = 0;
    obs_last_load = '0; timed_out = 0;
    prev_depth = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    done = 0;
    while (!done) begin
      @(negedge clk);
      obs_cycles++;
      if (stack_push) obs_q.push_back(stack_push_data);
      if (pc_inc) obs_inc++;
      if (pc_load) begin obs_load++; obs_last_load = pc_load_val; end
      obs_pop_total += int'(stack_pop);
      if ((pc_inc && pc_load) || (stack_push && stack_pop != 3'd0)) obs_proto++;
      if (depth != prev_depth) begin obs_depth_q.push_back(depth); prev_depth = depth; end
      if (halted) done = 1;
      else if (stop_wb && state_dbg == ST_WB) done = 1;
      else if (obs_cycles >= budget) begin timed_out = 1; done = 1; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({pc_inc, pc_load, stack_push, halted} !== 4'b0) begin
      n_errors++; $display("FAIL reset_strobes: got %b expected 0000", {pc_inc, pc_load, stack_push, halted});
    end
    n_checks++;
    if (stack_pop !== 3'd0 || pc_load_val !== 11'd0) begin
      n_errors++; $display("FAIL reset_pop_val: got pop=%0d val=%0h expected 0/0", stack_pop, pc_load_val);
    end
    n_checks++;
    if (stack_push_data !== 256'd0) begin
      n_errors++; $display("FAIL reset_push_data: got %0h expected 0", stack_push_data);
    end
    n_checks++;
    if (depth !== 8'd0 || fault !== 2'd0) begin
      n_errors++; $display("FAIL reset_depth_fault: got depth=%0d fault=%0d expected 0/0", depth, fault);
    end
    n_checks++;
    if (state_dbg !== ST_RESET) begin
      n_errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_RESET);
    end
  endtask

  task automatic test_sequence();
    clear_rom();
    ovr = 1'b0;
    rom[0] = 16'h1005; rom[1] = 16'h1007; rom[2] = 16'h3000; rom[3] = 16'hF000;
    ref_run(1'b0, '0, '0);
    run_prog(200, 1'b0);
    n_checks++;
    if (timed_out || halted !== 1'b1 || fault !== 2'd0) begin
      n_errors++; $display("FAIL seq_halt: got halted=%b fault=%0d timeout=%0d expected 1/0/0", halted, fault, timed_out);
    end
    n_checks++;
    if (obs_q.size() != 3) begin
      n_errors++; $display("FAIL seq_push_count: got %0d expected 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL seq_push[%0d]: got %0h expected %0h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (obs_depth_q.size() != 4 || obs_depth_q[0] !== 8'd1 || obs_depth_q[1] !== 8'd2 ||
        obs_depth_q[2] !== 8'd0 || obs_depth_q[3] !== 8'd1) begin
      n_errors++; $display("FAIL seq_depth_trace: got %p expected 1,2,0,1", obs_depth_q);
    end
    n_checks++;
    if (obs_inc != 3) begin
      n_errors++; $display("FAIL seq_pc_inc: got %0d expected 3", obs_inc);
    end
    n_checks++;
    if (obs_cycles != exp_cycles) begin
      n_errors++; $display("FAIL seq_cycles: got %0d expected %0d", obs_cycles, exp_cycles);
    end
  endtask

  task automatic test_add_wrap();
    clear_rom();
    rom[0] = 16'h1001; rom[1] = 16'h1001; rom[2] = 16'h3000; rom[3] = 16'hF000;
    ovr = 1'b1; ovr0 = '1; ovr1 = '1;
    ref_run(1'b1, ovr0, ovr1);
    run_prog(200, 1'b0);
    ovr = 1'b0;
    n_checks++;
    if (obs_q.size() != 3 || obs_q[2] !== exp_q[2]) begin
      n_errors++; $display("FAIL add_wrap_sum: got %0h expected %0h", obs_q.size() == 3 ? obs_q[2] : '0, exp_q[2]);
    end
    n_checks++;
    if (fault !== 2'd0 || halted !== 1'b1) begin
      n_errors++; $display("FAIL add_wrap_fault: got fault=%0d halted=%b expected 0/1", fault, halted);
    end
  endtask

  task automatic test_jz();
    // taken branch
    clear_rom();
    ovr = 1'b0;
    rom[0] = 16'h1000; rom[1] = 16'h5040; rom[2] = 16'h1077;
    ref_run(1'b0, '0, '0);
    run_prog(200, 1'b0);
    n_checks++;
    if (obs_load != 1 || obs_last_load !== 11'h040 || obs_inc != exp_inc) begin
      n_errors++; $display("FAIL jz_taken: got load=%0d val=%0h inc=%0d expected 1/040/%0d", obs_load, obs_last_load, obs_inc, exp_inc);
    end
    n_checks++;
    if (obs_pop_total != 1 || depth !== 8'd0 || obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL jz_taken_pop: got pops=%0d depth=%0d pushes=%0d expected 1/0/%0d", obs_pop_total, depth, obs_q.size(), exp_q.size());
    end
    // not taken
    rom[0] = 16'h1003;
    ref_run(1'b0, '0, '0);
    run_prog(200, 1'b0);
    n_checks++;
    if (obs_load != 0 || obs_inc != exp_inc || obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL jz_not_taken: got load=%0d inc=%0d pushes=%0d expected 0/%0d/%0d", obs_load, obs_inc, obs_q.size(), exp_inc, exp_q.size());
    end
    n_checks++;
    if (obs_cycles != exp_cycles || depth !== 8'd1) begin
      n_errors++; $display("FAIL jz_not_taken_cycles: got cycles=%0d depth=%0d expected %0d/1", obs_cycles, depth, exp_cycles);
    end
  endtask

  task automatic test_faults();
    // underflow: POP 3 at depth 2
    clear_rom();
    ovr = 1'b0;
    rom[0] = 16'h1001; rom[1] = 16'h1002; rom[2] = 16'h2003; rom[3] = 16'h1009;
    run_prog(200, 1'b0);
    n_checks++;
    if (fault !== 2'd1 || halted !== 1'b1 || obs_pop_total != 0 || obs_q.size() != 2 || depth !== 8'd2) begin
      n_errors++; $display("FAIL underflow: got fault=%0d halted=%b pops=%0d pushes=%0d depth=%0d expected 1/1/0/2/2",
                           fault, halted, obs_pop_total, obs_q.size(), depth);
    end
    // overflow: 129th push
    clear_rom();
    for (int i = 0; i < 129; i++) rom[i] = 16'h1000 | 16'(i);
    run_prog(600, 1'b0);
    n_checks++;
    if (fault !== 2'd2 || halted !== 1'b1 || obs_q.size() != 128 || depth !== 8'd128) begin
      n_errors++; $display("FAIL overflow: got fault=%0d halted=%b pushes=%0d depth=%0d expected 2/1/128/128",
                           fault, halted, obs_q.size(), depth);
    end
    // illegal opcode, then stays put
    clear_rom();
    rom[0] = 16'h9000;
    run_prog(200, 1'b0);
    n_checks++;
    if (fault !== 2'd3 || halted !== 1'b1 || obs_cycles != 3) begin
      n_errors++; $display("FAIL illegal: got fault=%0d halted=%b cycles=%0d expected 3/1/3", fault, halted, obs_cycles);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (fault !== 2'd3 || halted !== 1'b1 || depth !== 8'd0 ||
        {pc_inc, pc_load, stack_push} !== 3'b0 || stack_pop !== 3'd0) begin
      n_errors++; $display("FAIL halt_absorbing: got fault=%0d halted=%b depth=%0d strobes=%b pop=%0d expected 3/1/0/000/0",
                           fault, halted, depth, {pc_inc, pc_load, stack_push}, stack_pop);
    end
  endtask

  task automatic test_reset_in_wb();
    clear_rom();
    ovr = 1'b0;
    rom[0] = 16'h1005; rom[1] = 16'h1007; rom[2] = 16'h3000; rom[3] = 16'hF000;
    run_prog(200, 1'b1);
    n_checks++;
    if (timed_out || state_dbg !== ST_WB || stack_push !== 1'b1) begin
      n_errors++; $display("FAIL wb_reach: got state=%0d push=%b timeout=%0d expected %0d/1/0", state_dbg, stack_push, timed_out, ST_WB);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({pc_inc, stack_push, halted} !== 3'b0 || stack_push_data !== 256'd0 || depth !== 8'd0 ||
        fault !== 2'd0 || state_dbg !== ST_RESET) begin
      n_errors++; $display("FAIL wb_async_reset: got inc=%b push=%b data=%0h depth=%0d state=%0d expected all 0",
                           pc_inc, stack_push, stack_push_data, depth, state_dbg);
    end
    ref_run(1'b0, '0, '0);
    run_prog(200, 1'b0);
    n_checks++;
    if (obs_q.size() != 3 || obs_q[2] !== exp_q[2] || obs_cycles != exp_cycles) begin
      n_errors++; $display("FAIL wb_restart: got pushes=%0d cycles=%0d expected 3/%0d", obs_q.size(), obs_cycles, exp_cycles);
    end
  endtask

  task automatic test_random();
    int len, r, tgt;
    logic [11:0] imm;
    for (int it = 0; it < 20; it++) begin
      clear_rom();
      ovr = 1'b0;
      len = $urandom_range(8, 20);
      for (int i = 0; i < len; i++) begin
        r   = $urandom_range(0, 99);
        imm = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(0, 4095));
        tgt = $urandom_range(i + 1, len);
        if (r < 32)      rom[i] = {4'h1, imm};
        else if (r < 45) rom[i] = {4'h2, 9'd0, 3'($urandom_range(0, 3))};
        else if (r < 65) rom[i] = {4'h3, 12'd0};
        else if (r < 71) rom[i] = {4'h0, imm};
        else if (r < 79) rom[i] = {4'h4, 12'(tgt)};
        else if (r < 92) rom[i] = {4'h5, 12'(tgt)};
        else if (r < 96) rom[i] = {4'($urandom_range(6, 14)), imm};
        else             rom[i] = 16'hF000;
      end
      ref_run(1'b0, '0, '0);
      run_prog(500, 1'b0);
      n_checks++;
      if (timed_out || halted !== 1'b1 || fault !== exp_fault) begin
        n_errors++; $display("FAIL rnd%0d_end: got halted=%b fault=%0d timeout=%0d expected 1/%0d/0", it, halted, fault, timed_out, exp_fault);
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_errors++; $display("FAIL rnd%0d_push_count: got %0d expected %0d", it, obs_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_checks++;
          if (obs_q[i] !== exp_q[i]) begin
            n_errors++; $display("FAIL rnd%0d_push[%0d]: got %0h expected %0h", it, i, obs_q[i], exp_q[i]);
          end
        end
      end
      n_checks++;
      if (obs_depth_q != exp_depth_q) begin
        n_errors++; $display("FAIL rnd%0d_depth_trace: got %p expected %p", it, obs_depth_q, exp_depth_q);
      end
      n_checks++;
      if (obs_inc != exp_inc || obs_load != exp_load || obs_pop_total != exp_pop_total) begin
        n_errors++; $display("FAIL rnd%0d_strobes: got inc=%0d load=%0d pops=%0d expected %0d/%0d/%0d",
                             it, obs_inc, obs_load, obs_pop_total, exp_inc, exp_load, exp_pop_total);
      end
      n_checks++;
      if (exp_load > 0 && obs_last_load !== exp_last_load) begin
        n_errors++; $display("FAIL rnd%0d_load_val: got %0h expected %0h", it, obs_last_load, exp_last_load);
      end
      n_checks++;
      if (obs_cycles != exp_cycles || obs_proto != 0) begin
        n_errors++; $display("FAIL rnd%0d_timing: got cycles=%0d overlaps=%0d expected %0d/0", it, obs_cycles, obs_proto, exp_cycles);
      end
    end
  endtask

  // ---------------- main ----------------
  initial begin
    ovr  = 1'b0;
    ovr0 = '0;
    ovr1 = '0;
    clear_rom();
    test_reset();
    test_sequence();
    test_add_wrap();
    test_jz();
    test_faults();
    test_reset_in_wb();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
